// File: rtl/pb_disp_mmio.sv
// -----------------------------------------------------------------------------
// pb_disp_mmio
//
// Memory-mapped I/O responder on the CPU data bus. It serves debounced
// push-button state at 0xFB and holds four 7-segment digit patterns at
// 0xFC..0xFF. Those patterns are time-multiplexed onto an active-low
// common display.
//
// Optional feature macro: PB_EDGE_EN
//   Defined   : adds a sticky 3-bit rise register pb_edge, read at 0xFA and
//               cleared by a load (re=1) from 0xFA.
//   Undefined : 0xFA reads 8'h00 and re is ignored.
//
// Parameters
//   DEBOUNCE_CYC : cycles a synchronized button level must stay stable (>= 1)
//   SCAN_CYC     : cycles each digit stays lit before the scan advances (>= 1)
//
// Ports
//   clk    in   1  system clock
//   rst    in   1  synchronous active-high reset
//   addr   in   8  CPU data address
//   wdata  in   8  CPU store data
//   we     in   1  store strobe, qualified by addr
//   re     in   1  load strobe, qualified by addr (PB_EDGE_EN only)
//   rdata  out  8  load data, combinational from addr
//   pb_in  in   3  raw buttons, active-high, async; [1]=left [2]=right [0]=spare
//   seg    out  8  segment pattern {dp,g..a}, active-low, registered
//   an     out  4  digit enables, active-low, registered
// -----------------------------------------------------------------------------
module pb_disp_mmio #(
    parameter logic [15:0] DEBOUNCE_CYC = 16'd50000,
    parameter logic [15:0] SCAN_CYC     = 16'd25000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic       we,
    input  logic       re,
    output logic [7:0] rdata,
    input  logic [2:0] pb_in,
    output logic [7:0] seg,
    output logic [3:0] an
);

    localparam logic [7:0] ADDR_EDGE = 8'hFA;
    localparam logic [7:0] ADDR_PB   = 8'hFB;

    // Digit registers; index 0..3 maps to 0xFC..0xFF and an[0]..an[3].
    logic [7:0]  d [4];

    logic [2:0]  s1, s2;
    logic [2:0]  pb_stable, stable_nxt;
    logic [15:0] cnt     [3];
    logic [15:0] cnt_nxt [3];

    logic [15:0] scan_cnt;
    logic [1:0]  idx;

    // The digit window is the top four addresses, so the low two address
    // bits select the digit directly.
    logic wr_dig;
    assign wr_dig = we && (addr[7:2] == 6'h3F);

    // -------------------------------------------------------------------------
    // Digit register file
    // -------------------------------------------------------------------------
    // NOTE: the digit array is tiny and must come up blank, so it is reset
    // like ordinary flops; a large RAM would normally be left unreset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) d[i] <= 8'hFF;
        end else if (wr_dig) begin
            d[addr[1:0]] <= wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Synchronizer and per-bit debounce
    // -------------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of an always_comb, so
    // no path through the branches below can leave it unassigned (no latch).
    always_comb begin
        stable_nxt = pb_stable;
        for (int i = 0; i < 3; i++) begin
            cnt_nxt[i] = cnt[i];
            if (s2[i] == pb_stable[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] == DEBOUNCE_CYC - 16'd1) begin
                stable_nxt[i] = s2[i];
                cnt_nxt[i]    = '0;
            end else begin
                cnt_nxt[i] = cnt[i] + 16'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so that every flop
    // samples the pre-edge values; s1 -> s2 stays a true two-stage chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= '0;
            s2        <= '0;
            pb_stable <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            s1        <= pb_in;
            s2        <= s1;
            pb_stable <= stable_nxt;
            for (int i = 0; i < 3; i++) cnt[i] <= cnt_nxt[i];
        end
    end

    // -------------------------------------------------------------------------
    // Optional sticky rise register
    // -------------------------------------------------------------------------
`ifdef PB_EDGE_EN
    logic [2:0] pb_edge;
    logic       clr_edge;
    assign clr_edge = re && (addr == ADDR_EDGE);

    // A rise is flagged on the same edge pb_stable takes the new level. The
    // OR after the clear lets a coincident rise win over the clearing read.
    always_ff @(posedge clk) begin
        if (rst) begin
            pb_edge <= '0;
        end else begin
            pb_edge <= (clr_edge ? 3'b000 : pb_edge) | (stable_nxt & ~pb_stable);
        end
    end
`else
    // Without the edge feature the load strobe has no effect.
    logic unused_re;
    assign unused_re = re;
`endif

    // -------------------------------------------------------------------------
    // Display scan
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
            seg      <= 8'hFF;
            an       <= 4'b1111;
        end else begin
            if (scan_cnt == SCAN_CYC - 16'd1) begin
                scan_cnt <= '0;
                idx      <= idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 16'd1;
            end
            // Driven from the current idx/d, so the pins lag them by a cycle.
            an  <= ~(4'b0001 << idx);
            seg <= d[idx];
        end
    end

    // -------------------------------------------------------------------------
    // Zero-wait-state read mux
    // -------------------------------------------------------------------------
    always_comb begin
        rdata = 8'h00;
        if (addr[7:2] == 6'h3F) begin
            rdata = d[addr[1:0]];
        end else if (addr == ADDR_PB) begin
            rdata = {5'b0, pb_stable};
        end
`ifdef PB_EDGE_EN
        else if (addr == ADDR_EDGE) begin
            rdata = {5'b0, pb_edge};
        end
`endif
    end

endmodule

// File: tb/tb_pb_disp_mmio.sv
// -----------------------------------------------------------------------------
// tb_pb_disp_mmio
//
// Scoreboard bench for pb_disp_mmio with DEBOUNCE_CYC=4, SCAN_CYC=3.
// Stimulus drives the bus just after each rising edge and queues the values
// expected before the next edge. A monitor pops one entry on every falling
// edge and compares it with rdata / an / seg. Define PB_EDGE_EN to also cover
// the sticky edge register.
// -----------------------------------------------------------------------------
module tb_pb_disp_mmio;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] addr, wdata, rdata, seg;
    logic       we, re;
    logic [2:0] pb_in;
    logic [3:0] an;

    pb_disp_mmio #(
        .DEBOUNCE_CYC(16'd4),
        .SCAN_CYC    (16'd3)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .wdata(wdata),
        .we   (we),
        .re   (re),
        .rdata(rdata),
        .pb_in(pb_in),
        .seg  (seg),
        .an   (an)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        bit         chk_rd;
        logic [7:0] rd;
        bit         chk_disp;
        logic [3:0] an;
        logic [7:0] seg;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: one expectation per cycle, compared half a period after drive.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk_rd) check({e.name, ".rdata"}, rdata, e.rd);
                if (e.chk_disp) begin
                    check({e.name, ".an"}, {4'b0, an}, {4'b0, e.an});
                    check({e.name, ".seg"}, seg, e.seg);
                end
            end
        end
    end

    task automatic expect_now(input string name, input bit crd, input logic [7:0] rd,
                              input bit cd, input logic [3:0] an_e, input logic [7:0] seg_e);
        exp_t e;
        e.name = name; e.chk_rd = crd; e.rd = rd;
        e.chk_disp = cd; e.an = an_e; e.seg = seg_e;
        sb.push_back(e);
    endtask

    // Wait one rising edge, drive the bus for the next one, queue expectations.
    task automatic cyc(input string name, input logic [7:0] a, input logic w,
                       input logic [7:0] wd, input logic r, input bit crd,
                       input logic [7:0] rd, input bit cd = 1'b0,
                       input logic [3:0] an_e = 4'b0, input logic [7:0] seg_e = 8'h0);
        @(posedge clk);
        #1;
        addr = a; we = w; wdata = wd; re = r;
        expect_now(name, crd, rd, cd, an_e, seg_e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; we = 1'b0; re = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic [7:0] dig    [4] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
    logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] a_tmp;

    initial begin
        rst = 1'b1; addr = 8'h00; wdata = 8'h00; we = 1'b0; re = 1'b0; pb_in = 3'b000;

        // ---- 1: reset state and first cycle after release ----
        do_reset();
        addr = 8'hFB;
        expect_now("rst_state", 1'b1, 8'h00, 1'b1, 4'b1111, 8'hFF);
        rst = 1'b0;
        cyc("rel_fc", 8'hFC, 0, 8'h00, 0, 1, 8'hFF, 1, 4'b1110, 8'hFF);
        cyc("rel_fd", 8'hFD, 0, 8'h00, 0, 1, 8'hFF);
        cyc("rel_fe", 8'hFE, 0, 8'h00, 0, 1, 8'hFF);
        cyc("rel_ff", 8'hFF, 0, 8'h00, 0, 1, 8'hFF);

        // ---- 2: steady press of left, then release ----
        pb_in = 3'b010;
        for (int k = 1; k <= 8; k++)
            cyc($sformatf("press_k%0d", k), 8'hFB, 0, 8'h00, 0, 1, (k >= 6) ? 8'h02 : 8'h00);
        pb_in = 3'b000;
        for (int k = 1; k <= 8; k++)
            cyc($sformatf("release_k%0d", k), 8'hFB, 0, 8'h00, 0, 1, (k >= 6) ? 8'h00 : 8'h02);

        // ---- 3: 3-cycle glitch on right never gets through ----
        pb_in = 3'b100;
        for (int k = 1; k <= 12; k++) begin
            cyc($sformatf("glitch_k%0d", k), 8'hFB, 0, 8'h00, 0, 1, 8'h00);
            if (k == 3) pb_in = 3'b000;
        end

        // ---- 4: load digits and watch a full scan period ----
        do_reset();
        rst = 1'b0;
        // Same-cycle readback of a digit being written shows the old value.
        addr = 8'hFC; we = 1'b1; wdata = 8'hC0;
        expect_now("wr_fc_old", 1'b1, 8'hFF, 1'b0, 4'b0, 8'h0);
        cyc("wr_fd", 8'hFD, 1, 8'hF9, 0, 1, 8'hFF, 1, 4'b1110, 8'hFF);
        cyc("wr_fe", 8'hFE, 1, 8'hA4, 0, 1, 8'hFF);
        cyc("wr_ff", 8'hFF, 1, 8'hB0, 0, 1, 8'hFF);
        cyc("rb_ff", 8'hFF, 0, 8'h00, 0, 1, 8'hB0);
        for (int k = 5; k <= 12; k++)
            cyc($sformatf("idle_k%0d", k), 8'hFC, 0, 8'h00, 0, 1, 8'hC0);
        for (int k = 13; k <= 24; k++) begin
            a_tmp = 8'hFC + 8'((k - 13) / 3);
            cyc($sformatf("scan_k%0d", k), a_tmp, 0, 8'h00, 0, 1, dig[(k - 13) / 3],
                1, an_tab[(k - 13) / 3], dig[(k - 13) / 3]);
        end

        // ---- 5: writes outside the digit window are ignored ----
        cyc("wr_10", 8'h10, 1, 8'h55, 0, 1, 8'h00);
        cyc("wr_fb", 8'hFB, 1, 8'h55, 0, 1, 8'h00);
        cyc("rd_fb", 8'hFB, 0, 8'h00, 0, 1, 8'h00);
        cyc("rd_10", 8'h10, 0, 8'h00, 0, 1, 8'h00);
        cyc("keep_fc", 8'hFC, 0, 8'h00, 0, 1, 8'hC0);
        cyc("keep_fd", 8'hFD, 0, 8'h00, 0, 1, 8'hF9);
        cyc("keep_fe", 8'hFE, 0, 8'h00, 0, 1, 8'hA4);
        // 32 edges after release: scan sits on digit 2.
        cyc("keep_ff", 8'hFF, 0, 8'h00, 0, 1, 8'hB0, 1, 4'b1011, 8'hA4);
        // Reset mid-scan.
        rst = 1'b1;
        cyc("mid_rst", 8'hFC, 0, 8'h00, 0, 1, 8'hFF, 1, 4'b1111, 8'hFF);
        rst = 1'b0;
        cyc("post_fd", 8'hFD, 0, 8'h00, 0, 1, 8'hFF, 1, 4'b1110, 8'hFF);
        cyc("post_fe", 8'hFE, 0, 8'h00, 0, 1, 8'hFF);
        cyc("post_ff", 8'hFF, 0, 8'h00, 0, 1, 8'hFF);

`ifdef PB_EDGE_EN
        // ---- 6: sticky rise register ----
        cyc("edge_rst", 8'hFA, 0, 8'h00, 0, 1, 8'h00);
        pb_in = 3'b010;
        for (int k = 1; k <= 8; k++) cyc("edge_press", 8'hFB, 0, 8'h00, 0, 0, 8'h00);
        pb_in = 3'b000;
        for (int k = 1; k <= 8; k++) cyc("edge_rel", 8'hFB, 0, 8'h00, 0, 0, 8'h00);
        cyc("edge_held", 8'hFA, 0, 8'h00, 0, 1, 8'h02);
        cyc("edge_clr_rd", 8'hFA, 0, 8'h00, 1, 1, 8'h02);
        cyc("edge_cleared", 8'hFA, 0, 8'h00, 0, 1, 8'h00);
        // New press: pb_stable rises on edge 6, same edge as the clearing read.
        pb_in = 3'b010;
        for (int k = 1; k <= 7; k++)
            cyc($sformatf("edge_race_k%0d", k), 8'hFA, 0, 8'h00, (k == 5), 1,
                (k >= 6) ? 8'h02 : 8'h00);
        pb_in = 3'b000;
`else
        // ---- 6 (feature off): 0xFA reads zero, re has no effect ----
        cyc("fa_re", 8'hFA, 0, 8'h00, 1, 1, 8'h00);
        cyc("fa_rd", 8'hFA, 0, 8'h00, 0, 1, 8'h00);
`endif

        // Drain the scoreboard.
        repeat (3) @(posedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
